dbus_ctrl: RTL
==============

DBUS_CTRL -- requirements
Module: dbus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: bus cycles in ACCESS without ack before timeout error (range 1..1023).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req_i  in  1  MEM-stage load/store valid; held stable while stall_o=1.
REQ-005 SHALL have ports: we_i  in  1  1=store, 0=load.
REQ-006 SHALL have ports: size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have ports: sign_i  in  1  load sign-extend (1) / zero-extend (0).
REQ-008 SHALL have ports: addr_i  in  32  byte address; wdata_i  in  32  store data (low-aligned).
REQ-009 SHALL have ports: flush_i  in  1  pipeline flush (exception).
REQ-010 SHALL have ports: stall_o  out  1  freeze IF..MEM; rdata_o  out  32  extended load data.
REQ-011 SHALL have ports: done_o  out  1  one-cycle completion pulse; err_o  out  1  one-cycle misalign/timeout pulse.
REQ-012 SHALL have bus ports: bus_cyc_o out 1, bus_we_o out 1, bus_sel_o out 4, bus_adr_o out 32 (word-aligned, [1:0]=00), bus_dat_o out 32, bus_dat_i in 32, bus_ack_i in 1.

Function
REQ-013 SHALL implement FSM IDLE, ACCESS, DONE; all bus outputs registered.
REQ-014 IDLE: req_i & aligned & ~flush_i -> latch we/size/sign/addr lanes, load bus regs, goto ACCESS.
REQ-015 Misaligned = size 01 & addr[0]; size 10 & addr[1:0]!=0; size 11. IDLE & req_i & misaligned -> err_o=1 next cycle, no bus cycle, stay IDLE, stall_o=0.
REQ-016 ACCESS: bus_cyc_o=1; bus_ack_i -> capture rdata, goto DONE; bus_cyc_o drops the cycle after ack.
REQ-017 Timeout counter clears on ACCESS entry, increments each ACCESS cycle without ack; reaching TIMEOUT_CYC -> err_o pulse, goto DONE, rdata_o=0.
REQ-018 ack and timeout same cycle: ack wins, no err_o.
REQ-019 DONE: done_o=1, stall_o=0 for exactly one cycle, then IDLE (pipeline advances; next req_i is a new access).
REQ-020 stall_o = (IDLE & req_i & aligned & ~flush_i) | ACCESS; combinational.
REQ-021 flush_i in ACCESS: bus_cyc_o deasserts next cycle, goto IDLE, no done_o/err_o; flush beats simultaneous ack.
REQ-022 Latency: req at cycle N, bus_cyc_o high from N+1, ack at M>=N+1, done_o and rdata_o valid at M+1; minimum 3 cycles.
REQ-023 bus_sel_o: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111; bus_we_o=we_i.
REQ-024 bus_dat_o: byte replicated x4, half replicated x2, word as-is.
REQ-025 rdata_o: select lane by latched addr[1:0]/size, extend per sign_i; held until next DONE; stores leave rdata_o unchanged.

Reset
REQ-026 rst SHALL force IDLE, timeout counter 0, bus_cyc_o/bus_we_o 0, bus_sel_o 0, bus_adr_o/bus_dat_o 0, rdata_o 0, done_o/err_o 0; stall_o 0 while rst=1.
REQ-027 rst mid-ACCESS SHALL drop bus_cyc_o the next cycle; acks arriving thereafter are ignored.

Structure
REQ-028 Package dbus_pkg SHALL hold size encodings (SZ_BYTE/HALF/WORD), FSM state enum, TIMEOUT counter width constant.
REQ-029 Sub-module dbus_lane SHALL be combinational: sel generation, write replication, read lane extract and extension.

Verification
REQ-030 Load byte addr 0x1003, sign=1, bus_dat_i=0x80AABBCC, ack 2 cycles after cyc -> bus_sel_o=1000, rdata_o=0xFFFFFF80, done_o one pulse.
REQ-031 Store half addr 0x2002, wdata=0x1234 -> bus_sel_o=1100, bus_dat_o=0x12341234, bus_adr_o=0x2000, bus_we_o=1.
REQ-032 Load word addr 0x3001 -> err_o pulse, bus_cyc_o never asserted, stall_o=0.
REQ-033 TIMEOUT_CYC=4, no ack -> err_o after 4 ACCESS cycles, rdata_o=0, done_o pulse, back to IDLE.
REQ-034 flush_i coincident with ack in ACCESS -> no done_o, rdata_o unchanged, IDLE next cycle; rst mid-ACCESS -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared encodings for the data-bus controller: access sizes, FSM states,
// timeout counter width and the alignment rule applied when a request arrives.
package dbus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough for the largest supported TIMEOUT_CYC (1023)
    localparam int TO_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Size 11 has no legal encoding and is reported like a misaligned access
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dbus_lane.sv
// Byte-lane steering for the data bus: write strobes and data replication on
// the way out, lane extraction and sign/zero extension on the way back.
module dbus_lane
    import dbus_pkg::*;
(
    input  logic [1:0]  wr_size_i,
    input  logic [1:0]  wr_addr_lo_i,
    input  logic [31:0] wr_data_i,
    output logic [3:0]  wr_sel_o,
    output logic [31:0] wr_data_o,
    input  logic [1:0]  rd_size_i,
    input  logic [1:0]  rd_addr_lo_i,
    input  logic        rd_sign_i,
    input  logic [31:0] rd_data_i,
    output logic [31:0] rd_data_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (wr_size_i)
            SZ_BYTE: begin
                wr_sel_o  = 4'b0001 << wr_addr_lo_i;
                wr_data_o = {4{wr_data_i[7:0]}};
            end
            SZ_HALF: begin
                wr_sel_o  = 4'b0011 << {wr_addr_lo_i[1], 1'b0};
                wr_data_o = {2{wr_data_i[15:0]}};
            end
            default: begin
                wr_sel_o  = 4'b1111;
                wr_data_o = wr_data_i;
            end
        endcase
    end

    // Read side uses the fields latched at request time, not the live inputs
    always_comb begin
        rd_byte = rd_data_i[{rd_addr_lo_i, 3'b000} +: 8];
        rd_half = rd_data_i[{rd_addr_lo_i[1], 4'b0000} +: 16];
        case (rd_size_i)
            SZ_BYTE: rd_data_o = {{24{rd_sign_i & rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_data_o = {{16{rd_sign_i & rd_half[15]}}, rd_half};
            default: rd_data_o = rd_data_i;
        endcase
    end

endmodule

// File: rtl/dbus_ctrl.sv
// MEM-stage data-bus controller: turns a load/store request into one
// registered bus cycle, stalls the pipeline while it runs, reports done/error.
module dbus_ctrl
    import dbus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        bus_cyc_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic        bus_cyc_q, bus_cyc_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_adr_q, bus_adr_d;
    logic [31:0] bus_dat_q, bus_dat_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  alo_q, alo_d;

    logic        aligned;
    logic        accept;
    logic        in_access;
    logic        acked;
    logic        expired;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdat;
    logic [31:0] lane_rdata;

    assign aligned   = ~is_misaligned(size_i, addr_i[1:0]);
    assign accept    = (state_q == ST_IDLE) & req_i & aligned & ~flush_i;
    assign in_access = (state_q == ST_ACCESS);
    // Flush outranks ack, and ack outranks a timeout landing in the same cycle
    assign acked     = in_access & ~flush_i & bus_ack_i;
    assign expired   = in_access & ~flush_i & ~bus_ack_i & (cnt_q == TO_LAST);

    dbus_lane u_lane (
        .wr_size_i    (size_i),
        .wr_addr_lo_i (addr_i[1:0]),
        .wr_data_i    (wdata_i),
        .wr_sel_o     (lane_sel),
        .wr_data_o    (lane_wdat),
        .rd_size_i    (size_q),
        .rd_addr_lo_i (alo_q),
        .rd_sign_i    (sign_q),
        .rd_data_i    (bus_dat_i),
        .rd_data_o    (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bus_cyc_q <= 1'b0;
            bus_we_q  <= 1'b0;
            bus_sel_q <= '0;
            bus_adr_q <= '0;
            bus_dat_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_cyc_q <= bus_cyc_d;
            bus_we_q  <= bus_we_d;
            bus_sel_q <= bus_sel_d;
            bus_adr_q <= bus_adr_d;
            bus_dat_q <= bus_dat_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q   <= we_d;
        size_q <= size_d;
        sign_q <= sign_d;
        alo_q  <= alo_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (acked | expired) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o = ~rst & (accept | in_access);
        done_o  = ~rst & (state_q == ST_DONE);
        err_o   = ~rst & err_q;

        err_d     = ((state_q == ST_IDLE) & req_i & ~aligned) | expired;
        bus_cyc_d = (state_d == ST_ACCESS);

        bus_we_d  = bus_we_q;
        bus_sel_d = bus_sel_q;
        bus_adr_d = bus_adr_q;
        bus_dat_d = bus_dat_q;
        we_d      = we_q;
        size_d    = size_q;
        sign_d    = sign_q;
        alo_d     = alo_q;
        if (accept) begin
            bus_we_d  = we_i;
            bus_sel_d = lane_sel;
            bus_adr_d = {addr_i[31:2], 2'b00};
            bus_dat_d = lane_wdat;
            we_d      = we_i;
            size_d    = size_i;
            sign_d    = sign_i;
            alo_d     = addr_i[1:0];
        end

        // Stores leave the last load result in place; a timeout clears it
        rdata_d = rdata_q;
        if (acked & ~we_q) begin
            rdata_d = lane_rdata;
        end else if (expired) begin
            rdata_d = '0;
        end
    end

    assign bus_cyc_o = bus_cyc_q;
    assign bus_we_o  = bus_we_q;
    assign bus_sel_o = bus_sel_q;
    assign bus_adr_o = bus_adr_q;
    assign bus_dat_o = bus_dat_q;
    assign rdata_o   = rdata_q;

endmodule
